// File: rtl/wide_adder_pkg.sv
// Shared types and helpers for the nibble-serial wide adder.
// Holds the FSM state encoding, the slice width and the overflow rule.
package wide_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement overflow: like-signed operands giving an opposite-signed result.
   function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/ripple_adder_4bit_dataflow.sv
// 4-bit ripple-carry adder written as per-bit sum/carry equations.
// Used as the single shared datapath slice of the wide adder.
module ripple_adder_4bit_dataflow (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[4];

endmodule

// File: rtl/wide_adder_sequencer.sv
// Adds two 4*NIBBLES-bit operands one nibble per cycle through one 4-bit slice.
// Optional macro SUBTRACT_EN adds a 'sub' input that turns the operation into a - b.
module wide_adder_sequencer
   import wide_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                      carry_in,
`ifdef SUBTRACT_EN
   input  logic                      sub,
`endif
   output logic                      done_valid,
   input  logic                      done_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                      carry_out,
   output logic                      ovf,
   output logic                      busy,
   output state_t                    state_dbg
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. start_ready depends only on state/reset, never on start_valid;
   // done_valid stays high with a stable result until done_ready is seen.

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [W-1:0]         a_reg;
   logic [W-1:0]         b_reg;
   logic                 carry_reg;
   logic [NIBBLE_W-1:0]  a_nib;
   logic [NIBBLE_W-1:0]  b_nib;
   logic [NIBBLE_W-1:0]  slice_s;
   logic                 slice_c;
   logic                 last_nib;
   logic                 accept;
   logic [W-1:0]         b_load;
   logic                 c_load;

   assign a_nib    = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
   assign b_nib    = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
   assign last_nib = (idx == IDX_W'(NIBBLES - 1));

   assign start_ready = (state == IDLE) && !reset;
   assign accept      = start_valid && start_ready;
   assign busy        = (state != IDLE);
   assign state_dbg   = state;

`ifdef SUBTRACT_EN
   // a - b computed as a + ~b + 1; carry_in is not used for subtraction.
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : carry_in;
`else
   assign b_load = b;
   assign c_load = carry_in;
`endif

   ripple_adder_4bit_dataflow u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_reg),
      .s    (slice_s),
      .cout (slice_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         carry_reg  <= 1'b0;
         sum        <= '0;
         carry_out  <= 1'b0;
         ovf        <= 1'b0;
         done_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg     <= a;
                  b_reg     <= b_load;
                  carry_reg <= c_load;
                  idx       <= '0;
                  sum       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum[NIBBLE_W*int'(idx) +: NIBBLE_W] <= slice_s;
               carry_reg <= slice_c;
               if (last_nib) begin
                  idx        <= '0;
                  carry_out  <= slice_c;
                  ovf        <= ovf_calc(a_reg[W-1], b_reg[W-1], slice_s[NIBBLE_W-1]);
                  done_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (done_ready) begin
                  done_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               done_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// Directed bench for wide_adder_sequencer with NIBBLES=4 (16-bit operands).
// Subtraction vectors run only when SUBTRACT_EN is defined.
module tb_wide_adder_sequencer;
   import wide_adder_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic          clk;
   logic          reset;
   logic          start_valid;
   logic          start_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          carry_in;
   logic          sub_i;
   logic          done_valid;
   logic          done_ready;
   logic [W-1:0]  sum;
   logic          carry_out;
   logic          ovf;
   logic          busy;
   state_t        state_dbg;

   int total = 0;
   int bad   = 0;

   // expected {carry_out, ovf, sum}
   logic [W+1:0] exp_q[$];

   wide_adder_sequencer #(.NIBBLES(NIB)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .carry_in    (carry_in),
`ifdef SUBTRACT_EN
      .sub         (sub_i),
`endif
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .sum         (sum),
      .carry_out   (carry_out),
      .ovf         (ovf),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: present one operation for exactly one edge, then scramble inputs
   task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv);
      check("start_ready_at_accept", 32'(start_ready), 32'd1);
      a = av; b = bv; carry_in = cv; sub_i = sv; start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom); sub_i = 1'($urandom);
   endtask

   task automatic check_result(input string tag);
      int lat;
      logic [W+1:0] e;
      lat = 0;
      for (int i = 0; i < 20 && !done_valid; i++) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(NIB));
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
         check({tag, "_carry_out"}, 32'(carry_out), 32'(e[W+1]));
         check({tag, "_ovf"}, 32'(ovf), 32'(e[W]));
      end
   endtask

   task automatic handoff(input string tag);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      check({tag, "_done_valid_clear"}, 32'(done_valid), 32'd0);
      check({tag, "_start_ready_back"}, 32'(start_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv,
                         input logic [W-1:0] es, input logic ec, input logic ev);
      exp_q.push_back({ec, ev, es});
      accept_op(av, bv, cv, sv);
      check_result(tag);
      handoff(tag);
   endtask

   initial begin
      reset = 1'b1; start_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;
      sub_i = 1'b0; done_ready = 1'b0;
      repeat (3) step();

      // reset values
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_done_valid", 32'(done_valid), 32'd0);
      check("rst_carry_out", 32'(carry_out), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start_ready_low", 32'(start_ready), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      reset = 1'b0;
      #1;
      check("rst_start_ready_high", 32'(start_ready), 32'd1);
      step();

      // basic additions and boundary carries / overflow
      run_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_cin_only",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
      run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("add_8000_ffff_cin", 16'h8000, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0);

      // back-pressure: result held while start_valid is asserted
      exp_q.push_back({1'b0, 1'b0, 16'h5555});
      accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      check_result("hold_first");
      a = 16'h0F0F; b = 16'h00F1; carry_in = 1'b0; sub_i = 1'b0; start_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_sum", 32'(sum), 32'h5555);
         check("hold_done_valid", 32'(done_valid), 32'd1);
         check("hold_start_ready", 32'(start_ready), 32'd0);
      end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      check("hold_release_idle", 32'(state_dbg), 32'(IDLE));
      check("hold_release_ready", 32'(start_ready), 32'd1);
      check("hold_release_sum_kept", 32'(sum), 32'h5555);
      exp_q.push_back({1'b0, 1'b0, 16'h1000});
      step();
      start_valid = 1'b0;
      check("hold_next_accepted", 32'(busy), 32'd1);
      check("hold_next_sum_cleared", 32'(sum), 32'd0);
      check_result("hold_second");
      handoff("hold_second");

      // reset during the second RUN cycle discards the operation
      accept_op(16'hAAAA, 16'h1111, 1'b0, 1'b0);
      step();
      reset = 1'b1;
      step();
      check("midrun_state", 32'(state_dbg), 32'(IDLE));
      check("midrun_done_valid", 32'(done_valid), 32'd0);
      check("midrun_sum", 32'(sum), 32'd0);
      check("midrun_busy", 32'(busy), 32'd0);
      check("midrun_start_ready", 32'(start_ready), 32'd0);
      reset = 1'b0;
      #1;
      run_op("after_reset_1234_1111", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
      run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
